// File: rtl/weight_load_pkg.sv
// ---------------------------------------------------------------------------
// weight_load_pkg
//   Shared definitions for the weight-memory write side.
//   - State codes of the store sequencer. The weight memory decodes
//     weight_fsm_cs with the same constants, so they must not change.
//   - Default word counts for each stored layer.
//   - next_layer(): layer that follows a given store layer.
//   - is_store_state(): true for the layers that accept stream words.
// ---------------------------------------------------------------------------
package weight_load_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'b0000;
    localparam state_t ST_L1     = 4'b0001;
    localparam state_t ST_L2     = 4'b0010;
    localparam state_t ST_L4     = 4'b0011;
    localparam state_t ST_L5     = 4'b0100;
    localparam state_t ST_L7     = 4'b0101;
    localparam state_t ST_HOLD   = 4'b0110;
    localparam state_t ST_FINISH = 4'b1111;

    localparam int WORD_W     = 16;
    localparam int DEF_L1_NUM = 216;  // 3x3x3x8
    localparam int DEF_L2_NUM = 576;  // 3x3x8x8
    localparam int DEF_L4_NUM = 576;
    localparam int DEF_L5_NUM = 576;
    localparam int DEF_L7_NUM = 400;  // two 200-word banks

    // The value after L7 is never used for a store (L7 ends in FINISH and
    // a new start reloads L2), so it falls back to L2.
    function automatic state_t next_layer(input state_t s);
        case (s)
            ST_L1:   next_layer = ST_L2;
            ST_L2:   next_layer = ST_L4;
            ST_L4:   next_layer = ST_L5;
            ST_L5:   next_layer = ST_L7;
            default: next_layer = ST_L2;
        endcase
    endfunction

    function automatic logic is_store_state(input state_t s);
        is_store_state = (s == ST_L1) || (s == ST_L2) || (s == ST_L4) ||
                         (s == ST_L5) || (s == ST_L7);
    endfunction

endpackage

// File: rtl/weight_store_loader_if.sv
// ---------------------------------------------------------------------------
// weight_store_loader_if
//   Stream input and memory write port of the weight store loader.
//   master : the loader (consumes the stream, drives the write port)
//   slave  : host/DMA plus weight memory side
//   Signals:
//     in_valid, in_data      stream word offered to the loader
//     in_ready               loader accepts the word this cycle
//     write_weight_signal    memory write strobe
//     write_weight_addr      memory write address
//     write_weight_data      memory write data
// ---------------------------------------------------------------------------
interface weight_store_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              write_weight_signal;
    logic [ADDR_W-1:0] write_weight_addr;
    logic [DATA_W-1:0] write_weight_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output write_weight_signal,
        output write_weight_addr,
        output write_weight_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  write_weight_signal,
        input  write_weight_addr,
        input  write_weight_data
    );

endinterface

// File: rtl/weight_addr_counter.sv
// ---------------------------------------------------------------------------
// weight_addr_counter
//   Per-layer word counter; its value is the write address of the word
//   being accepted. Clear has priority over increment.
//   Ports:
//     clk    clock
//     rst    asynchronous, active-low reset (count -> 0)
//     clr    synchronous clear to 0
//     inc    increment by one
//     count  current count
// ---------------------------------------------------------------------------
module weight_addr_counter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/weight_store_loader.sv
// ---------------------------------------------------------------------------
// weight_store_loader
//   Write-side initiator for the weight local memory. Takes 16-bit weight
//   words over a valid/ready stream and writes them to the weight memory,
//   layer by layer (L1, L2, L4, L5, L7). Each layer restarts at address 0
//   because the memory is reused per layer. After each layer the loader
//   waits in HOLD for load_next; after L7 it parks in FINISH.
//
//   Ports:
//     clk                clock
//     rst                asynchronous, active-low reset
//     start              begin a full load sequence (IDLE/FINISH only)
//     load_next          load the next layer (HOLD only)
//     bus                stream + memory write port (master modport)
//     weight_fsm_cs      registered state code
//     weight_store_done  one-cycle pulse, cycle after the last layer write
//     weight_checksum    16-bit wrapping sum of the finished layer
//
//   Build option:
//     WEIGHT_CHECKSUM_EN  when defined, accumulates the layer checksum and
//                         latches it with weight_store_done; otherwise
//                         weight_checksum is tied to 0.
// ---------------------------------------------------------------------------
module weight_store_loader
    import weight_load_pkg::*;
#(
    parameter int L1_NUM = DEF_L1_NUM,
    parameter int L2_NUM = DEF_L2_NUM,
    parameter int L4_NUM = DEF_L4_NUM,
    parameter int L5_NUM = DEF_L5_NUM,
    parameter int L7_NUM = DEF_L7_NUM,
    parameter int ADDR_W = 16,
    parameter int DATA_W = WORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 load_next,
    weight_store_loader_if.master bus,
    output logic [3:0]           weight_fsm_cs,
    output logic                 weight_store_done,
    output logic [DATA_W-1:0]    weight_checksum
);

    state_t            state;
    state_t            next_layer_reg;
    logic [ADDR_W-1:0] count_p0;
    logic [ADDR_W-1:0] layer_last;
    logic              store_st;
    logic              start_ok;
    logic              next_ok;
    logic              xfer_p0;
    logic              last_p0;
    logic              cnt_clr_p0;
    logic              cnt_inc_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;
    logic              done_p1;
    logic              done_p2;

    // ---- stage p0: handshake, layer bookkeeping --------------------------
    assign store_st     = is_store_state(state);
    assign bus.in_ready = store_st;
    assign xfer_p0      = bus.in_valid && store_st;
    assign start_ok     = start && ((state == ST_IDLE) || (state == ST_FINISH));
    assign next_ok      = load_next && (state == ST_HOLD);

    always_comb begin
        layer_last = ADDR_W'(L1_NUM - 1);
        case (state)
            ST_L2:   layer_last = ADDR_W'(L2_NUM - 1);
            ST_L4:   layer_last = ADDR_W'(L4_NUM - 1);
            ST_L5:   layer_last = ADDR_W'(L5_NUM - 1);
            ST_L7:   layer_last = ADDR_W'(L7_NUM - 1);
            default: ;
        endcase
    end

    assign last_p0    = xfer_p0 && (count_p0 == layer_last);
    assign cnt_clr_p0 = start_ok || next_ok || last_p0;
    assign cnt_inc_p0 = xfer_p0;

    weight_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_p0),
        .inc   (cnt_inc_p0),
        .count (count_p0)
    );

    // start and load_next are mutually exclusive by state, so at most one
    // of start_ok / next_ok is ever set; the last word of a layer can only
    // arrive in a store state, where neither is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            next_layer_reg <= ST_L2;
        end else if (start_ok) begin
            state          <= ST_L1;
            next_layer_reg <= ST_L2;
        end else if (next_ok) begin
            state          <= next_layer_reg;
        end else if (last_p0) begin
            state          <= (state == ST_L7) ? ST_FINISH : ST_HOLD;
            next_layer_reg <= next_layer(state);
        end
    end

    assign weight_fsm_cs = state;

    // ---- stage p1: registered memory write port --------------------------
    // Address/data only load on a transfer so they hold between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            done_p1    <= 1'b0;
        end else begin
            vld_p1  <= xfer_p0;
            done_p1 <= last_p0;
            if (xfer_p0) begin
                wr_addr_p1 <= count_p0;
                wr_data_p1 <= bus.in_data;
            end
        end
    end

    assign bus.write_weight_signal = vld_p1;
    assign bus.write_weight_addr   = wr_addr_p1;
    assign bus.write_weight_data   = wr_data_p1;

    // ---- stage p2: layer done pulse --------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_p2 <= 1'b0;
        end else begin
            done_p2 <= done_p1;
        end
    end

    assign weight_store_done = done_p2;

`ifdef WEIGHT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_p1;
    logic [DATA_W-1:0] checksum_p2;

    // Sum is cleared on layer entry. When done_p1 is set the sum already
    // includes the last word, and a same-edge clear (load_next/start right
    // after the layer) still lets the old value be latched here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_p1 <= '0;
        end else if (start_ok || next_ok) begin
            sum_p1 <= '0;
        end else if (xfer_p0) begin
            sum_p1 <= sum_p1 + bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_p2 <= '0;
        end else if (done_p1) begin
            checksum_p2 <= sum_p1;
        end
    end

    assign weight_checksum = checksum_p2;
`else
    assign weight_checksum = '0;
`endif

endmodule
